// File: rtl/wb_bus_if.sv
// Wishbone B3 classic master bridge for one OpenMIPS memory port.
// Turns a single-cycle core request into a bus handshake and stalls the pipeline until ack.
module wb_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_we_i,
    input  logic [SEL_W-1:0]  cpu_sel_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              stallreq_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_we_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_STALL
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] rd_buf;

    // WAIT_STALL parks the bridge after ack so a frozen pipeline cannot re-issue the same access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            rd_buf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wb_adr_o <= cpu_addr_i;
                        wb_dat_o <= cpu_data_i;
                        wb_we_o  <= cpu_we_i;
                        wb_sel_o <= cpu_sel_i;
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        rd_buf   <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i || wb_ack_i) begin
                        wb_adr_o <= '0;
                        wb_dat_o <= '0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        if (flush_i) begin
                            state <= IDLE;
                        end else begin
                            if (!wb_we_o) begin
                                rd_buf <= wb_dat_i;
                            end
                            state <= (stall_i != 6'd0) ? WAIT_STALL : IDLE;
                        end
                    end
                end
                WAIT_STALL: begin
                    if (flush_i || stall_i == 6'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is forwarded on the ack cycle so the core sees it without an extra stall.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    stallreq_o = cpu_ce_i && !flush_i;
                    cpu_data_o = rd_buf;
                end
                BUSY: begin
                    stallreq_o = !wb_ack_i && !flush_i;
                    if (wb_ack_i && !wb_we_o) begin
                        cpu_data_o = wb_dat_i;
                    end
                end
                WAIT_STALL: begin
                    cpu_data_o = rd_buf;
                end
                default: begin
                    stallreq_o = 1'b0;
                    cpu_data_o = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_if.sv
// Directed-vector bench for wb_bus_if: each record drives one cycle and lists the outputs
// expected between edges; async reset is exercised by a hand-written sequence.
module tb_wb_bus_if;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;

    int total;
    int bad;

    wb_bus_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        ce;
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wb_dat;
        logic        ack;
        logic        e_req;
        logic [31:0] e_cpu;
        logic [31:0] e_adr;
        logic [31:0] e_dat;
        logic        e_we;
        logic [3:0]  e_sel;
        logic        e_bus;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [5:0] stall, input logic flush, input logic ce,
        input logic [31:0] addr, input logic [31:0] data, input logic we,
        input logic [3:0] sel, input logic [31:0] wb_dat, input logic ack,
        input logic e_req, input logic [31:0] e_cpu, input logic [31:0] e_adr,
        input logic [31:0] e_dat, input logic e_we, input logic [3:0] e_sel,
        input logic e_bus);
        vec_t v;
        v.stall = stall; v.flush = flush; v.ce = ce; v.addr = addr;
        v.data = data; v.we = we; v.sel = sel; v.wb_dat = wb_dat; v.ack = ack;
        v.e_req = e_req; v.e_cpu = e_cpu; v.e_adr = e_adr; v.e_dat = e_dat;
        v.e_we = e_we; v.e_sel = e_sel; v.e_bus = e_bus;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        @(negedge clk);
        stall_i    = v.stall;
        flush_i    = v.flush;
        cpu_ce_i   = v.ce;
        cpu_addr_i = v.addr;
        cpu_data_i = v.data;
        cpu_we_i   = v.we;
        cpu_sel_i  = v.sel;
        wb_dat_i   = v.wb_dat;
        wb_ack_i   = v.ack;
        #1;
        tag = $sformatf("v%0d", idx);
        checkOutput({tag, " stallreq"}, {31'd0, stallreq_o}, {31'd0, v.e_req});
        checkOutput({tag, " cpu_data"}, cpu_data_o, v.e_cpu);
        checkOutput({tag, " adr"}, wb_adr_o, v.e_adr);
        checkOutput({tag, " dat_o"}, wb_dat_o, v.e_dat);
        checkOutput({tag, " we"}, {31'd0, wb_we_o}, {31'd0, v.e_we});
        checkOutput({tag, " sel"}, {28'd0, wb_sel_o}, {28'd0, v.e_sel});
        checkOutput({tag, " stb"}, {31'd0, wb_stb_o}, {31'd0, v.e_bus});
        checkOutput({tag, " cyc"}, {31'd0, wb_cyc_o}, {31'd0, v.e_bus});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b1; cpu_addr_i = 32'h10;
        cpu_data_i = '0; cpu_we_i = 1'b0; cpu_sel_i = 4'hF; wb_dat_i = 32'h5555_AAAA;
        wb_ack_i = 1'b0;

        // Outputs must stay quiet while reset is held, even with a request pending.
        repeat (2) @(negedge clk);
        checkOutput("rst stallreq", {31'd0, stallreq_o}, 32'd0);
        checkOutput("rst cpu_data", cpu_data_o, 32'd0);
        checkOutput("rst stb", {31'd0, wb_stb_o}, 32'd0);
        checkOutput("rst adr", wb_adr_o, 32'd0);
        cpu_ce_i = 1'b0;
        rst = 1'b0;

        // stall flush ce addr data we sel wb_dat ack | req cpu adr dat we sel bus
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,         0, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,   32'h0,         0, 4'h0, 0));
        // read with two wait cycles
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h0,         0, 4'hF, 32'h0,         0, 1, 32'h0,         32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h0,         0, 4'hF, 32'h0,         0, 1, 32'h0,         32'h100, 32'h0,         0, 4'hF, 1));
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h0,         0, 4'hF, 32'h0,         0, 1, 32'h0,         32'h100, 32'h0,         0, 4'hF, 1));
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'h0,         0, 4'hF, 32'hDEADBEEF,  1, 0, 32'hDEADBEEF,  32'h100, 32'h0,         0, 4'hF, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,         0, 4'h0, 32'h0,         0, 0, 32'hDEADBEEF,  32'h0,   32'h0,         0, 4'h0, 0));
        // write with immediate ack
        vecs.push_back(mk(0, 0, 1, 32'h20,  32'h12345678,  1, 4'h3, 32'h0,         0, 1, 32'hDEADBEEF,  32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h20,  32'h12345678,  1, 4'h3, 32'hAAAA5555,  1, 0, 32'h0,         32'h20,  32'h12345678,  1, 4'h3, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,         0, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,   32'h0,         0, 4'h0, 0));
        // read acked while pipeline stalled
        vecs.push_back(mk(0, 0, 1, 32'h40,  32'h0,         0, 4'hF, 32'h0,         0, 1, 32'h0,         32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(7, 0, 1, 32'h40,  32'h0,         0, 4'hF, 32'hCAFEF00D,  1, 0, 32'hCAFEF00D,  32'h40,  32'h0,         0, 4'hF, 1));
        vecs.push_back(mk(7, 0, 1, 32'h40,  32'h0,         0, 4'hF, 32'h0,         0, 0, 32'hCAFEF00D,  32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(7, 0, 1, 32'h40,  32'h0,         0, 4'hF, 32'h0,         0, 0, 32'hCAFEF00D,  32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(7, 0, 1, 32'h40,  32'h0,         0, 4'hF, 32'h0,         0, 0, 32'hCAFEF00D,  32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,         0, 4'h0, 32'h0,         0, 0, 32'hCAFEF00D,  32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,         0, 4'h0, 32'h0,         0, 0, 32'hCAFEF00D,  32'h0,   32'h0,         0, 4'h0, 0));
        // flush before ack, then a stray ack
        vecs.push_back(mk(0, 0, 1, 32'h80,  32'h0,         0, 4'hF, 32'h0,         0, 1, 32'hCAFEF00D,  32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h80,  32'h0,         0, 4'hF, 32'h0,         0, 0, 32'h0,         32'h80,  32'h0,         0, 4'hF, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,         0, 4'h0, 32'hBADBAD00,  1, 0, 32'h0,         32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,         0, 4'h0, 32'h0,         0, 0, 32'h0,         32'h0,   32'h0,         0, 4'h0, 0));
        // back-to-back reads
        vecs.push_back(mk(0, 0, 1, 32'h0,   32'h0,         0, 4'hF, 32'h0,         0, 1, 32'h0,         32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,   32'h0,         0, 4'hF, 32'h11111111,  1, 0, 32'h11111111,  32'h0,   32'h0,         0, 4'hF, 1));
        vecs.push_back(mk(0, 0, 1, 32'h4,   32'h0,         0, 4'hF, 32'h0,         0, 1, 32'h11111111,  32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h4,   32'h0,         0, 4'hF, 32'h22222222,  1, 0, 32'h22222222,  32'h4,   32'h0,         0, 4'hF, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,         0, 4'h0, 32'h0,         0, 0, 32'h22222222,  32'h0,   32'h0,         0, 4'h0, 0));
        // flush in IDLE suppresses the request and keeps rd_buf
        vecs.push_back(mk(0, 1, 1, 32'h8,   32'h0,         0, 4'hF, 32'h0,         0, 0, 32'h22222222,  32'h0,   32'h0,         0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   32'h0,         0, 4'h0, 32'h0,         0, 0, 32'h22222222,  32'h0,   32'h0,         0, 4'h0, 0));

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Async reset asserted between edges while BUSY.
        @(negedge clk);
        cpu_ce_i = 1'b1; cpu_addr_i = 32'h200; cpu_we_i = 1'b0; cpu_sel_i = 4'hF;
        wb_ack_i = 1'b0; flush_i = 1'b0; stall_i = '0;
        #1;
        checkOutput("ar req", {31'd0, stallreq_o}, 32'd1);
        @(negedge clk);
        #1;
        checkOutput("ar busy stb", {31'd0, wb_stb_o}, 32'd1);
        checkOutput("ar busy adr", wb_adr_o, 32'h200);
        #1 rst = 1'b1;
        #1;
        checkOutput("ar stb", {31'd0, wb_stb_o}, 32'd0);
        checkOutput("ar cyc", {31'd0, wb_cyc_o}, 32'd0);
        checkOutput("ar adr", wb_adr_o, 32'd0);
        checkOutput("ar sel", {28'd0, wb_sel_o}, 32'd0);
        checkOutput("ar stallreq", {31'd0, stallreq_o}, 32'd0);
        checkOutput("ar cpu_data", cpu_data_o, 32'd0);
        cpu_ce_i = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("ar idle stb", {31'd0, wb_stb_o}, 32'd0);
        checkOutput("ar idle stallreq", {31'd0, stallreq_o}, 32'd0);
        cpu_ce_i = 1'b1;
        #1;
        checkOutput("ar idle req", {31'd0, stallreq_o}, 32'd1);
        checkOutput("ar idle cpu_data", cpu_data_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
